// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between requesters A and B.
// Each operation walks IDLE -> ISSUE -> WAIT -> RESP; operands are latched on grant.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqA,
    input  logic             reqB,
    input  logic [3:0]       opA,
    input  logic [3:0]       opB,
    input  logic [WIDTH-1:0] aA,
    input  logic [WIDTH-1:0] bA,
    input  logic [WIDTH-1:0] aB,
    input  logic [WIDTH-1:0] bB,
    output logic             grantA,
    output logic             grantB,
    output logic             doneA,
    output logic             doneB,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy,
    output logic [WIDTH-1:0] alu_inOne,
    output logic [WIDTH-1:0] alu_inTwo,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic               ownerB_q, ownerB_d;
    logic               lastB_q, lastB_d;
    logic               pickB;
    logic               grantA_q, grantA_d, grantB_q, grantB_d;
    logic               doneA_q, doneA_d, doneB_q, doneB_d;
    logic [WIDTH-1:0]   aluOne_q, aluOne_d, aluTwo_q, aluTwo_d;
    logic [3:0]         aluOp_q, aluOp_d;
    logic [WIDTH-1:0]   rspResult_q, rspResult_d;
    logic               rspCarry_q, rspCarry_d, rspZero_q, rspZero_d;

    always_comb begin
        state_d     = state_q;
        ownerB_d    = ownerB_q;
        lastB_d     = lastB_q;
        aluOne_d    = aluOne_q;
        aluTwo_d    = aluTwo_q;
        aluOp_d     = aluOp_q;
        rspResult_d = rspResult_q;
        rspCarry_d  = rspCarry_q;
        rspZero_d   = rspZero_q;
        grantA_d    = 1'b0;
        grantB_d    = 1'b0;
        doneA_d     = 1'b0;
        doneB_d     = 1'b0;
        // On a tie, B wins only if A was granted last.
        pickB       = reqB && (!reqA || !lastB_q);

        unique case (state_q)
            StIdle: begin
                if (reqA || reqB) begin
                    state_d  = StIssue;
                    ownerB_d = pickB;
                    lastB_d  = pickB;
                    aluOp_d  = pickB ? opB : opA;
                    aluOne_d = pickB ? aB : aA;
                    aluTwo_d = pickB ? bB : bA;
                    grantA_d = !pickB;
                    grantB_d = pickB;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                state_d     = StResp;
                rspResult_d = alu_result;
                rspCarry_d  = alu_carry;
                rspZero_d   = alu_zero;
                doneA_d     = !ownerB_q;
                doneB_d     = ownerB_q;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            ownerB_q    <= 1'b0;
            lastB_q     <= 1'b1;
            aluOne_q    <= '0;
            aluTwo_q    <= '0;
            aluOp_q     <= 4'b0000;
            rspResult_q <= '0;
            rspCarry_q  <= 1'b0;
            rspZero_q   <= 1'b0;
            grantA_q    <= 1'b0;
            grantB_q    <= 1'b0;
            doneA_q     <= 1'b0;
            doneB_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ownerB_q    <= ownerB_d;
            lastB_q     <= lastB_d;
            aluOne_q    <= aluOne_d;
            aluTwo_q    <= aluTwo_d;
            aluOp_q     <= aluOp_d;
            rspResult_q <= rspResult_d;
            rspCarry_q  <= rspCarry_d;
            rspZero_q   <= rspZero_d;
            grantA_q    <= grantA_d;
            grantB_q    <= grantB_d;
            doneA_q     <= doneA_d;
            doneB_q     <= doneB_d;
        end
    end

    assign grantA     = grantA_q;
    assign grantB     = grantB_q;
    assign doneA      = doneA_q;
    assign doneB      = doneB_q;
    assign busy       = (state_q != StIdle);
    assign rsp_result = rspResult_q;
    assign rsp_carry  = rspCarry_q;
    assign rsp_zero   = rspZero_q;
    assign alu_inOne  = aluOne_q;
    assign alu_inTwo  = aluTwo_q;
    assign alu_opcode = aluOp_q;

endmodule
